// File: rtl/conv_expand_engine.sv
// conv_expand_engine
//   Fire-module expand convolution engine. A DSP_NO-wide signed MAC array takes
//   one pixel per accepted cycle together with one kernel word per output
//   channel (read combinationally from a ROM at o_rom_addr). After
//   T = KERNEL_DIM*KERNEL_DIM*CHIN taps it adds the bias, shifts right by FRAC,
//   applies optional ReLU, saturates to WIDTH bits and presents the window on o_ofm.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start               one-cycle pulse, begins a layer (only honoured in IDLE)
//   i_pix_in/i_pix_valid  pixel stream in, o_pix_ready accepts it
//   o_rom_addr            tap index of the next pixel to be accepted
//   i_ker_in              DSP_NO kernel words valid for o_rom_addr
//   i_bias_in             DSP_NO biases, 2*WIDTH each, stable during a layer
//   o_ofm/o_ofm_valid     window result, taken by i_ofm_ready
//   o_busy, o_finish      layer status; o_finish held until i_ram_feedback
//   o_dbg_state           current control state
//
// Handshakes: a word moves only on a cycle where its valid and ready are both
// high at the rising edge. A producer holds its word stable while valid is
// high and ready is low; ready may depend combinationally on the other side.
module conv_expand_engine #(
    parameter int DSP_NO     = 128,
    parameter int WIDTH      = 16,
    parameter int CHIN       = 32,
    parameter int KERNEL_DIM = 3,
    parameter int WOUT       = 32,
    parameter int FRAC       = 14,
    parameter int RELU       = 1
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst_n,
    input  logic                                         i_start,
    input  logic signed [WIDTH-1:0]                      i_pix_in,
    input  logic                                         i_pix_valid,
    output logic                                         o_pix_ready,
    output logic [$clog2(KERNEL_DIM*KERNEL_DIM*CHIN)-1:0] o_rom_addr,
    input  logic [DSP_NO*WIDTH-1:0]                      i_ker_in,
    input  logic [DSP_NO*2*WIDTH-1:0]                    i_bias_in,
    output logic [DSP_NO*WIDTH-1:0]                      o_ofm,
    output logic                                         o_ofm_valid,
    input  logic                                         i_ofm_ready,
    output logic                                         o_busy,
    output logic                                         o_finish,
    input  logic                                         i_ram_feedback,
    output logic [1:0]                                   o_dbg_state
);

    localparam int T     = KERNEL_DIM * KERNEL_DIM * CHIN;
    localparam int TAP_W = $clog2(T);
    localparam int ACC_W = 2 * WIDTH + TAP_W;
    localparam int WIN_N = WOUT * WOUT;
    localparam int WIN_W = $clog2(WIN_N) + 1;
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(T - 1);
    localparam logic [WIN_W-1:0] LAST_WIN = WIN_W'(WIN_N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [TAP_W-1:0] r_tap;
    logic [WIN_W-1:0] r_win;
    logic             w_accept;
    logic             w_handoff;
    logic             w_pix_ready;

    logic                    r_s1_valid;
    logic                    r_s1_first;
    logic                    r_s1_last;
    logic signed [WIDTH-1:0] r_s1_pix;
    logic                    r_s2_last;
    logic                    r_ofm_valid;

    assign w_handoff = r_ofm_valid && i_ofm_ready;
    // Only the closing tap of a window waits for the output slot; it may go in
    // on the very edge the slot drains, so no bubble is inserted.
    assign w_pix_ready = (r_state == S_RUN) &&
                         !((r_tap == LAST_TAP) && r_ofm_valid && !i_ofm_ready);
    assign w_accept = i_pix_valid && w_pix_ready;

    // ---------------- control FSM ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_RUN;
            S_RUN:   if (w_handoff && (r_win == LAST_WIN)) w_next = S_DONE;
            S_DONE:  if (i_ram_feedback) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- tap / window counters ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tap <= '0;
            r_win <= '0;
        end else if ((r_state == S_IDLE) && i_start) begin
            r_tap <= '0;
            r_win <= '0;
        end else begin
            if (w_accept) r_tap <= (r_tap == LAST_TAP) ? '0 : r_tap + 1'b1;
            if (w_handoff) r_win <= r_win + 1'b1;
        end
    end

    // ---------------- stage 1: shared pixel and tap flags ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_pix   <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_pix   <= i_pix_in;
                r_s1_first <= (r_tap == '0);
                r_s1_last  <= (r_tap == LAST_TAP);
            end
        end
    end

    // ---------------- stage 2 completion flag and output slot ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s2_last   <= 1'b0;
            r_ofm_valid <= 1'b0;
        end else begin
            r_s2_last <= r_s1_valid && r_s1_last;
            // A fresh result loading wins over a drain on the same edge.
            if (r_s2_last)      r_ofm_valid <= 1'b1;
            else if (w_handoff) r_ofm_valid <= 1'b0;
        end
    end

    // ---------------- per-channel MAC and output formatting ----------------
    for (genvar g = 0; g < DSP_NO; g++) begin : g_ch
        logic signed [WIDTH-1:0]   r_ker;
        logic signed [ACC_W-1:0]   r_acc;
        logic signed [WIDTH-1:0]   r_ofm;
        logic signed [2*WIDTH-1:0] w_pix_ext;
        logic signed [2*WIDTH-1:0] w_ker_ext;
        logic signed [2*WIDTH-1:0] w_prod;
        logic signed [ACC_W-1:0]   w_prod_ext;
        logic signed [2*WIDTH-1:0] w_bias;
        logic signed [ACC_W:0]     w_sum;
        logic signed [ACC_W:0]     w_shr;
        logic                      w_ovf;
        logic signed [WIDTH-1:0]   w_res;

        assign w_pix_ext  = {{WIDTH{r_s1_pix[WIDTH-1]}}, r_s1_pix};
        assign w_ker_ext  = {{WIDTH{r_ker[WIDTH-1]}}, r_ker};
        assign w_prod     = w_pix_ext * w_ker_ext;
        assign w_prod_ext = {{TAP_W{w_prod[2*WIDTH-1]}}, w_prod};
        assign w_bias     = i_bias_in[g*2*WIDTH +: 2*WIDTH];
        // One extra bit keeps acc + bias from wrapping before the shift.
        assign w_sum = {r_acc[ACC_W-1], r_acc} +
                       {{(TAP_W+1){w_bias[2*WIDTH-1]}}, w_bias};
        assign w_shr = w_sum >>> FRAC;
        // Out of range when the bits above the result sign are not all copies of it.
        assign w_ovf = (w_shr[ACC_W:WIDTH-1] != {(ACC_W-WIDTH+2){w_shr[ACC_W]}});

        always_comb begin
            w_res = w_shr[WIDTH-1:0];
            if ((RELU != 0) && w_shr[ACC_W])
                w_res = '0;
            else if (w_ovf)
                w_res = w_shr[ACC_W] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_ker <= '0;
                r_acc <= '0;
                r_ofm <= '0;
            end else begin
                if (w_accept)   r_ker <= i_ker_in[g*WIDTH +: WIDTH];
                if (r_s1_valid) r_acc <= r_s1_first ? w_prod_ext : r_acc + w_prod_ext;
                if (r_s2_last)  r_ofm <= w_res;
            end
        end

        assign o_ofm[g*WIDTH +: WIDTH] = r_ofm;
    end

    assign o_pix_ready = w_pix_ready;
    assign o_rom_addr  = r_tap;
    assign o_ofm_valid = r_ofm_valid;
    assign o_busy      = (r_state != S_IDLE);
    assign o_finish    = (r_state == S_DONE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_conv_expand_engine.sv
// Bench for conv_expand_engine: two instances (RELU=1 and RELU=0) share all
// inputs. Windows are driven tap by tap; a window-level arithmetic model
// produces the expected words, a compare process checks every handoff and the
// hold-stable rule, and directed checks pin literal results and control timing.
module tb_conv_expand_engine;

    localparam int T = 9;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        start     = 1'b0;
    logic        pix_valid = 1'b0;
    logic        ofm_ready = 1'b0;
    logic        ram_fb    = 1'b0;
    logic [15:0] pix_in    = 16'h0;
    logic [31:0] ker_in;
    logic [63:0] bias_in;

    logic [31:0] bias_ch[2];
    logic [15:0] pix_tab[9];
    logic [15:0] ker_tab[9][2];

    logic        pix_ready_r, ofm_valid_r, busy_r, finish_r;
    logic        pix_ready_l, ofm_valid_l, busy_l, finish_l;
    logic [3:0]  rom_addr_r, rom_addr_l;
    logic [31:0] ofm_r, ofm_l;
    logic [1:0]  st_r, st_l;

    int n_cmp = 0;
    int n_bad = 0;
    int n_ho  = 0;
    logic [31:0] exp_q_relu[$];
    logic [31:0] exp_q_lin[$];
    logic [31:0] last_r = 32'h0;
    logic [31:0] last_l = 32'h0;

    assign ker_in  = {ker_tab[rom_addr_r][1], ker_tab[rom_addr_r][0]};
    assign bias_in = {bias_ch[1], bias_ch[0]};

    always #5 clk = ~clk;

    conv_expand_engine #(.DSP_NO(2), .WIDTH(16), .CHIN(1), .KERNEL_DIM(3),
                         .WOUT(2), .FRAC(14), .RELU(1)) dut_relu (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_pix_in(pix_in), .i_pix_valid(pix_valid), .o_pix_ready(pix_ready_r),
        .o_rom_addr(rom_addr_r), .i_ker_in(ker_in), .i_bias_in(bias_in),
        .o_ofm(ofm_r), .o_ofm_valid(ofm_valid_r), .i_ofm_ready(ofm_ready),
        .o_busy(busy_r), .o_finish(finish_r), .i_ram_feedback(ram_fb),
        .o_dbg_state(st_r)
    );

    conv_expand_engine #(.DSP_NO(2), .WIDTH(16), .CHIN(1), .KERNEL_DIM(3),
                         .WOUT(2), .FRAC(14), .RELU(0)) dut_lin (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_pix_in(pix_in), .i_pix_valid(pix_valid), .o_pix_ready(pix_ready_l),
        .o_rom_addr(rom_addr_l), .i_ker_in(ker_in), .i_bias_in(bias_in),
        .o_ofm(ofm_l), .o_ofm_valid(ofm_valid_l), .i_ofm_ready(ofm_ready),
        .o_busy(busy_l), .o_finish(finish_l), .i_ram_feedback(ram_fb),
        .o_dbg_state(st_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Window model: full dot product, bias, arithmetic shift, ReLU, clamp.
    function automatic logic [15:0] model_ch(input int ch, input bit relu);
        longint acc;
        longint s;
        acc = 0;
        for (int t = 0; t < T; t++)
            acc += longint'($signed(pix_tab[t])) * longint'($signed(ker_tab[t][ch]));
        acc += longint'($signed(bias_ch[ch]));
        s = acc >>> 14;
        if (relu && s < 0) return 16'h0000;
        if (s > 32767)     return 16'h7FFF;
        if (s < -32768)    return 16'h8000;
        return 16'(s);
    endfunction

    task automatic push_expect();
        exp_q_relu.push_back({model_ch(1, 1'b1), model_ch(0, 1'b1)});
        exp_q_lin.push_back({model_ch(1, 1'b0), model_ch(0, 1'b0)});
    endtask

    task automatic set_tables(input logic [15:0] p, input logic [15:0] k);
        for (int t = 0; t < T; t++) begin
            pix_tab[t]    = p;
            ker_tab[t][0] = k;
            ker_tab[t][1] = k;
        end
    endtask

    // Offer one tap and wait (bounded) until it is accepted; returns 1 time unit after the accepting edge.
    task automatic drive_tap(input logic [15:0] p, input int t);
        int g;
        g = 0;
        pix_in    = p;
        pix_valid = 1'b1;
        @(negedge clk);
        while (pix_ready_r !== 1'b1 && g < 100) begin
            g++;
            @(negedge clk);
        end
        check("tap_accept", 32'(pix_ready_r), 32'd1);
        check("rom_addr", 32'(rom_addr_r), t);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
    endtask

    task automatic run_window();
        for (int t = 0; t < T; t++) drive_tap(pix_tab[t], t);
        push_expect();
    endtask

    task automatic wait_ho(input int target);
        int g;
        g = 0;
        while (n_ho < target && g < 200) begin
            @(posedge clk);
            g++;
        end
        check("handoff_count", n_ho, target);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_fb();
        ram_fb = 1'b1;
        @(posedge clk);
        #1;
        ram_fb = 1'b0;
    endtask

    task automatic check_reset_vals();
        check("rst_pix_ready", 32'({pix_ready_r, pix_ready_l}), 32'd0);
        check("rst_rom_addr", 32'({rom_addr_r, rom_addr_l}), 32'd0);
        check("rst_ofm_relu", ofm_r, 32'd0);
        check("rst_ofm_lin", ofm_l, 32'd0);
        check("rst_ofm_valid", 32'({ofm_valid_r, ofm_valid_l}), 32'd0);
        check("rst_busy_finish", 32'({busy_r, busy_l, finish_r, finish_l}), 32'd0);
    endtask

    // Compare process: every handoff against the model, and held words stay put.
    initial begin : compare
        logic        hold;
        logic [31:0] h_r;
        logic [31:0] h_l;
        hold = 1'b0;
        h_r  = '0;
        h_l  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", 32'({ofm_valid_r, ofm_valid_l}), 32'd3);
                    check("hold_ofm_relu", ofm_r, h_r);
                    check("hold_ofm_lin", ofm_l, h_l);
                end
                if (ofm_valid_r && ofm_ready) begin
                    n_ho++;
                    last_r = ofm_r;
                    if (exp_q_relu.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL ofm_relu_extra: got 0x%08h want no window", ofm_r);
                    end else check("ofm_relu", ofm_r, exp_q_relu.pop_front());
                end
                if (ofm_valid_l && ofm_ready) begin
                    last_l = ofm_l;
                    if (exp_q_lin.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL ofm_lin_extra: got 0x%08h want no window", ofm_l);
                    end else check("ofm_lin", ofm_l, exp_q_lin.pop_front());
                end
                hold = ofm_valid_r && !ofm_ready;
                h_r  = ofm_r;
                h_l  = ofm_l;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout want summary");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int base;
        bias_ch[0] = 32'h0;
        bias_ch[1] = 32'h0000_4000;
        set_tables(16'h0100, 16'h0100);

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- layer A ----
        pulse_start();
        check("start_busy", 32'({busy_r, pix_ready_r}), 32'd3);
        check("start_finish", 32'(finish_r), 32'd0);

        // window 0: basic MAC + bias, slot left full
        ofm_ready = 1'b0;
        run_window();
        @(negedge clk); check("lat_c1", 32'(ofm_valid_r), 32'd0);
        @(negedge clk); check("lat_c2", 32'(ofm_valid_r), 32'd0);
        @(negedge clk); check("lat_c3", 32'(ofm_valid_r), 32'd1);
        check("w0_relu_lit", ofm_r, 32'h0025_0024);
        check("w0_lin_lit", ofm_l, 32'h0025_0024);
        @(posedge clk);
        #1;

        // window 1: negative kernel, last tap stalls behind window 0
        set_tables(16'h0100, 16'hFF00);
        for (int t = 0; t < T - 1; t++) drive_tap(pix_tab[t], t);
        pix_in    = pix_tab[8];
        pix_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("bp_pix_ready", 32'(pix_ready_r), 32'd0);
            check("bp_rom_addr", 32'(rom_addr_r), 32'd8);
            check("bp_ofm_kept", ofm_r, 32'h0025_0024);
        end
        @(posedge clk);
        #1;
        ofm_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 32'(pix_ready_r), 32'd1);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        push_expect();
        @(negedge clk); check("w1_lat_c1", 32'(ofm_valid_r), 32'd0);
        @(negedge clk); check("w1_lat_c2", 32'(ofm_valid_r), 32'd0);
        @(negedge clk); check("w1_lat_c3", 32'(ofm_valid_r), 32'd1);
        check("w1_relu_lit", ofm_r, 32'h0000_0000);
        check("w1_lin_lit", ofm_l, 32'hFFDD_FFDC);
        @(posedge clk);
        #1;

        // window 2: positive saturation
        set_tables(16'h7FFF, 16'h7FFF);
        run_window();
        wait_ho(3);
        #1;
        check("w2_relu_lit", last_r, 32'h7FFF_7FFF);
        check("w2_lin_lit", last_l, 32'h7FFF_7FFF);

        // window 3: negative saturation, last of the layer
        set_tables(16'h8000, 16'h7FFF);
        run_window();
        wait_ho(4);
        @(negedge clk);
        check("done_flags", 32'({finish_r, busy_r, pix_ready_r}), 32'd6);
        check("done_flags_lin", 32'({finish_l, busy_l}), 32'd3);
        check("w3_relu_lit", last_r, 32'h0000_0000);
        check("w3_lin_lit", last_l, 32'h8000_8000);
        @(posedge clk);
        #1;

        // start while DONE is ignored
        pulse_start();
        repeat (2) @(posedge clk);
        #1;
        check("done_start_ignored", 32'({finish_r, busy_r, pix_ready_r}), 32'd6);
        pulse_fb();
        check("feedback_idle", 32'({finish_r, busy_r, pix_ready_r}), 32'd0);

        // ---- layer B: mixed values, reset in the middle of window 1 ----
        bias_ch[0] = 32'hFFFF_E000;
        bias_ch[1] = 32'h0001_2345;
        for (int t = 0; t < T; t++) begin
            pix_tab[t]    = 16'(t * 300 - 1000);
            ker_tab[t][0] = 16'(2000 - t * 450);
            ker_tab[t][1] = 16'(t * t * 97 + 5);
        end
        pulse_start();
        check("b_start", 32'({busy_r, rom_addr_r}), 32'h10);
        pulse_fb();
        check("fb_in_run_ignored", 32'({busy_r, finish_r}), 32'd2);
        run_window();
        for (int t = 0; t < 5; t++) drive_tap(16'h0100, t);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        check("q_empty_at_reset", exp_q_relu.size() + exp_q_lin.size(), 32'd0);
        exp_q_relu.delete();
        exp_q_lin.delete();
        repeat (2) @(posedge clk);
        #1;
        check("rst_held_addr", 32'(rom_addr_r), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- layer C: restart after reset ----
        bias_ch[0] = 32'h0;
        bias_ch[1] = 32'h0000_4000;
        set_tables(16'h0100, 16'h0100);
        pulse_start();
        base = n_ho;
        run_window();
        wait_ho(base + 1);
        #1;
        check("after_rst_relu_lit", last_r, 32'h0025_0024);
        check("after_rst_lin_lit", last_l, 32'h0025_0024);

        repeat (3) @(posedge clk);
        check("final_q_empty", exp_q_relu.size() + exp_q_lin.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_expand_engine.md
# conv_expand_engine

Parametrised fire-module expand convolution engine: a DSP_NO-wide signed MAC array that takes one input pixel per accepted cycle and a matching kernel word per output channel. It accumulates KERNEL_DIM²·CHIN taps per output window, then adds bias, shifts, applies optional ReLU and saturates. Unlike earlier fixed expand layers, it has a full reset, a valid/ready output handshake with backpressure, pixel-side flow control and a start/finish/ram_feedback control FSM. It sits between the squeeze-output RAM (pixel source), the per-layer weight/bias ROMs (addressed via rom_addr) and the next-layer RAM writer.

## Interface
- DSP_NO, 128, output channels computed in parallel
- WIDTH, 16, pixel/kernel/ofm word width (signed Q format)
- CHIN, 32, input channels per window
- KERNEL_DIM, 3, window edge; T = KERNEL_DIM²·CHIN taps per window; T ≥ 3 required
- WOUT, 32, output edge; WOUT² windows per layer
- FRAC, 14, right-shift applied to the biased accumulator
- RELU, 1, 1 = clamp negatives to 0
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse, begins a layer; ignored unless IDLE
- pix_in  in  WIDTH  signed pixel for current tap
- pix_valid  in  1  pix_in valid
- pix_ready  out  1  engine accepts pix_in this cycle
- rom_addr  out  clog2(T)  tap index of next pixel; ker_in/bias_in must be valid for it in same cycle (combinational ROM)
- ker_in  in  DSP_NO×WIDTH  signed kernel words at rom_addr
- bias_in  in  DSP_NO×2·WIDTH  signed biases, stable during layer
- ofm  out  DSP_NO×WIDTH  result words
- ofm_valid  out  1  ofm holds an unconsumed window
- ofm_ready  in  1  consumer takes ofm this cycle
- busy  out  1  state ≠ IDLE
- finish  out  1  layer complete, held until ram_feedback
- ram_feedback  in  1  pulse, acknowledges finish

## Operation
- FSM: IDLE -start-> RUN; RUN -> DONE when the WOUT²-th window is handed off (ofm_valid && ofm_ready); DONE -ram_feedback-> IDLE. start outside IDLE is ignored. ram_feedback outside DONE is ignored.
- Accept = pix_valid && pix_ready. Each accept advances tap counter/rom_addr, wrapping T-1 -> 0.
- pix_ready = RUN && !(tap == T-1 && ofm_valid && !ofm_ready). Only the last tap of a window stalls on a full output slot; the last tap is accepted in the same cycle the slot drains.
- Pipeline: stage 1 registers pix, kernels, first/last flags. Stage 2 forms the WIDTH×WIDTH → 2·WIDTH signed product; acc = first ? prod : acc + prod. ACC_W = 2·WIDTH + clog2(T), signed.
- Output stage, on the last-tap flag: sum = acc + sign-extended bias; s = sum >>> FRAC (arithmetic, truncate toward −∞). If RELU and s < 0 then 0; otherwise saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1]. ofm is latched and ofm_valid set.
- ofm_valid clears on ofm_valid && ofm_ready unless a new result loads at the same edge (load wins).
- Window counter (clog2(WOUT²)+1 bits) increments per handoff and clears on start.
- Reset mid-operation: every register clears asynchronously; the in-flight window is discarded; the next start restarts from tap 0, window 0.

## Timing
- Reset values: pix_ready 0, rom_addr 0, ofm all 0, ofm_valid 0, busy 0, finish 0, FSM IDLE.
- start at edge e: busy and pix_ready high from cycle e+1.
- Last tap accepted at edge n: ofm_valid high from cycle n+3; ofm stable while ofm_valid && !ofm_ready.
- No-backpressure throughput: one tap per cycle, one window per T cycles, no bubbles between windows.
- finish rises the cycle after the final handoff edge and falls the cycle after the ram_feedback edge; busy falls together with finish.

## Test plan
Bench parameters: DSP_NO=2, CHIN=1, KERNEL_DIM=3 (T=9), WOUT=2, FRAC=14, WIDTH=16.
- Basic MAC, bias: pix=0x0100, ker=0x0100 on both channels, bias 0 -> ofm=36 (0x0024). Bias 0x00004000 on channel 1 -> channel 1 = 37. ofm_valid 3 cycles after the 9th accept.
- Sign: ker=0xFF00 (−256) -> RELU=1 gives 0x0000; RELU=0 gives 0xFFDC (−36).
- Saturation: pix=ker=0x7FFF for all 9 taps -> 0x7FFF. pix=0x8000, ker=0x7FFF, RELU=0 -> 0x8000.
- Backpressure: ofm_ready=0 after window 0 -> pix_ready drops at tap 8 of window 1; rom_addr holds 8; ofm keeps window 0. Raising ofm_ready accepts tap 8 the same cycle, and window 1 appears 3 cycles later with no data loss.
- Layer control: 4 handoffs -> finish=1, busy=1, pix_ready=0. A start pulse in DONE has no effect. ram_feedback -> finish=0, busy=0. A new start restarts at rom_addr 0.
- Async reset: rst low at tap 5 of window 1, between edges -> all outputs at reset values immediately. After release and start, window 0 result is correct (36).
